// File: rtl/glm_dram_load_if.sv
// CCI-P channel-0 types used by the DRAM line loader, plus an interface that
// bundles the loader's host-side channel and its BRAM write port.
package glm_ccip_pkg;
  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_WRLINE = 4'h1,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;
endpackage

interface glm_dram_load_if #(parameter int BRAM_AWIDTH = 10);
  logic                         c0TxAlmFull;
  glm_ccip_pkg::t_if_ccip_c0_Rx cp2af_sRx_c0;
  glm_ccip_pkg::t_if_ccip_c0_Tx af2cp_sTx_c0;
  logic                         mem_we;
  logic [BRAM_AWIDTH-1:0]       mem_waddr;
  logic [511:0]                 mem_wdata;

  // master = loader side, slave = host/BRAM side
  modport master (
    input  c0TxAlmFull, cp2af_sRx_c0,
    output af2cp_sTx_c0, mem_we, mem_waddr, mem_wdata
  );
  modport slave (
    output c0TxAlmFull, cp2af_sRx_c0,
    input  af2cp_sTx_c0, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/glm_dram_load.sv
// Streams cfg_length cache lines from DRAM over CCI-P channel 0 into a BRAM,
// tolerating out-of-order responses by addressing the BRAM with the returned mdata.
module glm_dram_load
  import glm_ccip_pkg::*;
#(
  parameter int BRAM_AWIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_start,
  output logic                   op_done,
  input  logic [31:0]            cfg_offset,
  input  logic [15:0]            cfg_length,
  input  logic [BRAM_AWIDTH-1:0] cfg_bram_base,
  input  t_ccip_clAddr           in_addr,
  input  t_ccip_clAddr           out_addr,
  input  logic                   c0TxAlmFull,
  input  t_if_ccip_c0_Rx         cp2af_sRx_c0,
  output t_if_ccip_c0_Tx         af2cp_sTx_c0,
  output logic                   mem_we,
  output logic [BRAM_AWIDTH-1:0] mem_waddr,
  output logic [511:0]           mem_wdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  t_ccip_clAddr           base;
  logic [15:0]            length;
  logic [15:0]            num_req;
  logic [15:0]            num_rsp;
  logic [BRAM_AWIDTH-1:0] bram_base;
  logic                   issue;
  logic                   accept;
  logic                   unused_rx;

  assign issue  = (state == RUN) && (num_req < length) && !c0TxAlmFull;
  // mmio and non-read responses share the channel; only read-line data is ours
  assign accept = (state == RUN) && cp2af_sRx_c0.rspValid &&
                  (cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE);

  assign unused_rx = ^{cp2af_sRx_c0.hdr, cp2af_sRx_c0.mmioRdValid, cp2af_sRx_c0.mmioWrValid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      base         <= '0;
      length       <= '0;
      num_req      <= '0;
      num_rsp      <= '0;
      bram_base    <= '0;
      op_done      <= 1'b0;
      af2cp_sTx_c0 <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
    end else begin
      af2cp_sTx_c0 <= '0;
      mem_we       <= 1'b0;
      op_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (op_start) begin
            base      <= (cfg_offset[31] ? out_addr : in_addr) + t_ccip_clAddr'(cfg_offset[30:0]);
            length    <= cfg_length;
            bram_base <= cfg_bram_base;
            num_req   <= '0;
            num_rsp   <= '0;
            state     <= (cfg_length == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            af2cp_sTx_c0.valid            <= 1'b1;
            af2cp_sTx_c0.hdr.vc_sel       <= eVC_VA;
            af2cp_sTx_c0.hdr.cl_len       <= eCL_LEN_1;
            af2cp_sTx_c0.hdr.req_type     <= eREQ_RDLINE_I;
            af2cp_sTx_c0.hdr.address      <= base + t_ccip_clAddr'(num_req);
            af2cp_sTx_c0.hdr.mdata        <= num_req;
            num_req                       <= num_req + 16'd1;
          end
          if (accept) begin
            mem_we    <= 1'b1;
            mem_waddr <= bram_base + cp2af_sRx_c0.hdr.mdata[BRAM_AWIDTH-1:0];
            mem_wdata <= cp2af_sRx_c0.data;
            num_rsp   <= num_rsp + 16'd1;
            if (16'(num_rsp + 16'd1) == length) state <= DONE;
          end
        end
        DONE: begin
          op_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
